// File: rtl/axi_rd_arbiter_pkg.sv
// Shared AXI4 read-channel encodings, field widths and the port-index width helper
// for the multi-port read arbiter.
package axi_rd_arbiter_pkg;

  localparam int unsigned LEN_W    = 8;
  localparam int unsigned SIZE_W   = 3;
  localparam int unsigned BURST_W  = 2;
  localparam int unsigned LOCK_W   = 1;
  localparam int unsigned CACHE_W  = 4;
  localparam int unsigned PROT_W   = 3;
  localparam int unsigned QOS_W    = 4;
  localparam int unsigned REGION_W = 4;
  localparam int unsigned RESP_W   = 2;

  typedef enum logic [BURST_W-1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  // AR attributes that travel with every request, independent of ID/address widths
  typedef struct packed {
    logic [LEN_W-1:0]    len;
    logic [SIZE_W-1:0]   size;
    logic [BURST_W-1:0]  burst;
    logic [LOCK_W-1:0]   lock;
    logic [CACHE_W-1:0]  cache;
    logic [PROT_W-1:0]   prot;
    logic [QOS_W-1:0]    qos;
    logic [REGION_W-1:0] region;
  } ar_attr_t;

  function automatic int unsigned port_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_arb_rr.sv
// Round-robin arbiter: combinational one-hot grant searching from the port after the
// last grant; the pointer moves only when advance_i is high and something is granted.
module arb_rr
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IW = port_idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic [IW-1:0] last_q;

  always_comb begin
    int   cand;
    logic found;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    for (int k = 1; k <= int'(N); k++) begin
      cand = (int'(last_q) + k) % int'(N);
      if (!found && req_i[IW'(cand)]) begin
        grant_o[IW'(cand)] = 1'b1;
        grant_idx_o        = IW'(cand);
        found              = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
    end else if (advance_i && (|req_i)) begin
      last_q <= grant_idx_o;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// N:1 AXI4 read arbiter: round-robin AR arbitration into a single output register,
// per-port outstanding-burst limiting, and ID-based combinational R demux.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned S_COUNT         = 2,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned S_ID_WIDTH      = 8,
  parameter int unsigned M_ID_WIDTH      = S_ID_WIDTH + $clog2(S_COUNT),
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [S_COUNT*S_ID_WIDTH-1:0]    s_axi_arid,
  input  logic [S_COUNT*ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic [S_COUNT*LEN_W-1:0]         s_axi_arlen,
  input  logic [S_COUNT*SIZE_W-1:0]        s_axi_arsize,
  input  logic [S_COUNT*BURST_W-1:0]       s_axi_arburst,
  input  logic [S_COUNT*LOCK_W-1:0]        s_axi_arlock,
  input  logic [S_COUNT*CACHE_W-1:0]       s_axi_arcache,
  input  logic [S_COUNT*PROT_W-1:0]        s_axi_arprot,
  input  logic [S_COUNT*QOS_W-1:0]         s_axi_arqos,
  input  logic [S_COUNT*REGION_W-1:0]      s_axi_arregion,
  input  logic [S_COUNT-1:0]               s_axi_arvalid,
  output logic [S_COUNT-1:0]               s_axi_arready,
  output logic [S_COUNT*S_ID_WIDTH-1:0]    s_axi_rid,
  output logic [S_COUNT*DATA_WIDTH-1:0]    s_axi_rdata,
  output logic [S_COUNT*RESP_W-1:0]        s_axi_rresp,
  output logic [S_COUNT-1:0]               s_axi_rlast,
  output logic [S_COUNT-1:0]               s_axi_rvalid,
  input  logic [S_COUNT-1:0]               s_axi_rready,
  output logic [M_ID_WIDTH-1:0]            m_axi_arid,
  output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
  output logic [LEN_W-1:0]                 m_axi_arlen,
  output logic [SIZE_W-1:0]                m_axi_arsize,
  output logic [BURST_W-1:0]               m_axi_arburst,
  output logic [LOCK_W-1:0]                m_axi_arlock,
  output logic [CACHE_W-1:0]               m_axi_arcache,
  output logic [PROT_W-1:0]                m_axi_arprot,
  output logic [QOS_W-1:0]                 m_axi_arqos,
  output logic [REGION_W-1:0]              m_axi_arregion,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  input  logic [M_ID_WIDTH-1:0]            m_axi_rid,
  input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
  input  logic [RESP_W-1:0]                m_axi_rresp,
  input  logic                             m_axi_rlast,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready,
  output logic                             decode_err
);

  localparam int unsigned IW = port_idx_w(S_COUNT);
  localparam int unsigned PW = M_ID_WIDTH - S_ID_WIDTH;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic [S_ID_WIDTH-1:0] arid_a [S_COUNT];
  logic [ADDR_WIDTH-1:0] addr_a [S_COUNT];
  ar_attr_t              attr_a [S_COUNT];

  logic [S_COUNT-1:0] eligible;
  logic [S_COUNT-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_en;
  logic               ar_load;

  logic                  arvalid_q;
  logic [M_ID_WIDTH-1:0] arid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  ar_attr_t              attr_q;

  logic [CW-1:0]      cnt_q [S_COUNT];
  logic [CW-1:0]      cnt_d [S_COUNT];
  logic [S_COUNT-1:0] r_done;

  logic [PW-1:0] rport;
  logic          decode_err_q;

  // Unpack the flat per-port buses; R payload is broadcast, only rvalid is steered
  for (genvar g = 0; g < S_COUNT; g++) begin : g_port
    assign arid_a[g] = s_axi_arid[g*S_ID_WIDTH +: S_ID_WIDTH];
    assign addr_a[g] = s_axi_araddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign attr_a[g] = '{len:    s_axi_arlen[g*LEN_W +: LEN_W],
                         size:   s_axi_arsize[g*SIZE_W +: SIZE_W],
                         burst:  s_axi_arburst[g*BURST_W +: BURST_W],
                         lock:   s_axi_arlock[g*LOCK_W +: LOCK_W],
                         cache:  s_axi_arcache[g*CACHE_W +: CACHE_W],
                         prot:   s_axi_arprot[g*PROT_W +: PROT_W],
                         qos:    s_axi_arqos[g*QOS_W +: QOS_W],
                         region: s_axi_arregion[g*REGION_W +: REGION_W]};
    assign eligible[g] = s_axi_arvalid[g] && (cnt_q[g] < CW'(MAX_OUTSTANDING));
    assign s_axi_rid[g*S_ID_WIDTH +: S_ID_WIDTH]   = m_axi_rid[S_ID_WIDTH-1:0];
    assign s_axi_rdata[g*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
    assign s_axi_rresp[g*RESP_W +: RESP_W]         = m_axi_rresp;
    assign s_axi_rlast[g]                          = m_axi_rlast;
    assign r_done[g] = s_axi_rvalid[g] && s_axi_rready[g] && m_axi_rlast;
  end

  arb_rr #(.N(S_COUNT)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (eligible),
    .advance_i   (grant_en),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign grant_en      = !rst && (!arvalid_q || m_axi_arready);
  assign ar_load       = grant_en && (|grant);
  assign s_axi_arready = grant & {S_COUNT{grant_en}};

  // AR output register: holds until accepted, may reload in the accepting cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid_q <= 1'b0;
    end else if (ar_load) begin
      arvalid_q <= 1'b1;
      arid_q    <= {PW'(grant_idx), arid_a[grant_idx]};
      araddr_q  <= addr_a[grant_idx];
      attr_q    <= attr_a[grant_idx];
    end else if (m_axi_arready) begin
      arvalid_q <= 1'b0;
    end
  end

  assign m_axi_arvalid  = arvalid_q;
  assign m_axi_arid     = arid_q;
  assign m_axi_araddr   = araddr_q;
  assign m_axi_arlen    = attr_q.len;
  assign m_axi_arsize   = attr_q.size;
  assign m_axi_arburst  = attr_q.burst;
  assign m_axi_arlock   = attr_q.lock;
  assign m_axi_arcache  = attr_q.cache;
  assign m_axi_arprot   = attr_q.prot;
  assign m_axi_arqos    = attr_q.qos;
  assign m_axi_arregion = attr_q.region;

  // R demux; beats addressed beyond the last port are swallowed
  assign rport = m_axi_rid[M_ID_WIDTH-1:S_ID_WIDTH];

  always_comb begin
    s_axi_rvalid = '0;
    m_axi_rready = 1'b1;
    for (int i = 0; i < int'(S_COUNT); i++) begin
      if (rport == PW'(i)) begin
        s_axi_rvalid[i] = m_axi_rvalid;
        m_axi_rready    = s_axi_rready[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(S_COUNT); i++) begin
      cnt_d[i] = cnt_q[i];
      if (s_axi_arready[i] && !r_done[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (r_done[i] && !s_axi_arready[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(S_COUNT); i++) cnt_q[i] <= '0;
      decode_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(S_COUNT); i++) cnt_q[i] <= cnt_d[i];
      decode_err_q <= m_axi_rvalid && (32'(rport) >= S_COUNT);
    end
  end

  assign decode_err = decode_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter (3 ports, 4 outstanding): directed scenarios then random
// traffic, all compared against a transaction-level model of grants, counts and routing.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  localparam int S    = 3;
  localparam int SID  = 8;
  localparam int MID  = 10;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MAXO = 4;

  logic clk, rst;
  logic [S*SID-1:0]      s_arid;
  logic [S*AW-1:0]       s_araddr;
  logic [S*LEN_W-1:0]    s_arlen;
  logic [S*SIZE_W-1:0]   s_arsize;
  logic [S*BURST_W-1:0]  s_arburst;
  logic [S*LOCK_W-1:0]   s_arlock;
  logic [S*CACHE_W-1:0]  s_arcache;
  logic [S*PROT_W-1:0]   s_arprot;
  logic [S*QOS_W-1:0]    s_arqos;
  logic [S*REGION_W-1:0] s_arregion;
  logic [S-1:0]          s_arvalid, s_arready;
  logic [S*SID-1:0]      s_rid;
  logic [S*DW-1:0]       s_rdata;
  logic [S*RESP_W-1:0]   s_rresp;
  logic [S-1:0]          s_rlast, s_rvalid, s_rready;
  logic [MID-1:0]        m_arid;
  logic [AW-1:0]         m_araddr;
  logic [LEN_W-1:0]      m_arlen;
  logic [SIZE_W-1:0]     m_arsize;
  logic [BURST_W-1:0]    m_arburst;
  logic [LOCK_W-1:0]     m_arlock;
  logic [CACHE_W-1:0]    m_arcache;
  logic [PROT_W-1:0]     m_arprot;
  logic [QOS_W-1:0]      m_arqos;
  logic [REGION_W-1:0]   m_arregion;
  logic                  m_arvalid, m_arready;
  logic [MID-1:0]        m_rid;
  logic [DW-1:0]         m_rdata;
  logic [RESP_W-1:0]     m_rresp;
  logic                  m_rlast, m_rvalid, m_rready;
  logic                  decode_err;

  logic [SID-1:0]   tb_arid  [S];
  logic [AW-1:0]    tb_araddr[S];
  logic [LEN_W-1:0] tb_arlen [S];

  always_comb begin
    s_arid   = {tb_arid[2], tb_arid[1], tb_arid[0]};
    s_araddr = {tb_araddr[2], tb_araddr[1], tb_araddr[0]};
    s_arlen  = {tb_arlen[2], tb_arlen[1], tb_arlen[0]};
  end

  assign s_arsize   = {S{3'd2}};
  assign s_arburst  = {S{BURST_INCR}};
  assign s_arlock   = '0;
  assign s_arcache  = {S{4'h3}};
  assign s_arprot   = '0;
  assign s_arqos    = '0;
  assign s_arregion = '0;

  axi_rd_arbiter #(
    .S_COUNT(S), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .S_ID_WIDTH(SID),
    .M_ID_WIDTH(MID), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen),
    .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst), .s_axi_arlock(s_arlock),
    .s_axi_arcache(s_arcache), .s_axi_arprot(s_arprot), .s_axi_arqos(s_arqos),
    .s_axi_arregion(s_arregion), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
    .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp),
    .s_axi_rlast(s_rlast), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
    .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
    .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock),
    .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot), .m_axi_arqos(m_arqos),
    .m_axi_arregion(m_arregion), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp),
    .m_axi_rlast(m_rlast), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
    .decode_err(decode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: outstanding bursts per port, last grant, pending AR
  int             cnt[S];
  int             last_gnt;
  bit             ar_vld;
  logic [MID-1:0] ar_id;
  logic [AW-1:0]  ar_addr;
  logic [7:0]     ar_len;
  bit             dec_exp;

  logic [S-1:0] obs_ard, obs_rv;
  logic         obs_rr;
  logic [MID-1:0] held_id;
  logic [AW-1:0]  held_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input bit [S-1:0] elig, input int from);
    for (int k = 1; k <= S; k++) begin
      int c;
      c = (from + k) % S;
      if (((elig >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  // One clock: check combinational outputs, advance the model at the edge,
  // then check registered outputs on the falling edge.
  task automatic cycle();
    int gp, p;
    bit [S-1:0] elig;
    logic [S-1:0] exp_ard, exp_rv;
    logic exp_rr;
    bit rhs;
    #1;
    for (int i = 0; i < S; i++) elig[i] = s_arvalid[i] && (cnt[i] < MAXO);
    gp = -1;
    if (!rst && (!ar_vld || m_arready)) gp = rr_pick(elig, last_gnt);
    exp_ard = (gp >= 0) ? S'(1 << gp) : '0;
    chk("arready", 64'(s_arready), 64'(exp_ard));
    p = int'(m_rid[MID-1:SID]);
    exp_rv = (p < S && m_rvalid) ? S'(1 << p) : '0;
    exp_rr = (p < S) ? 1'(s_rready >> p) : 1'b1;
    chk("r_valid_route", 64'(s_rvalid), 64'(exp_rv));
    chk("m_rready", 64'(m_rready), 64'(exp_rr));
    if (p < S && m_rvalid) begin
      chk("r_id", 64'(8'(s_rid >> (SID*p))), 64'(m_rid[SID-1:0]));
      chk("r_data", 64'(32'(s_rdata >> (DW*p))), 64'(m_rdata));
      chk("r_last", 64'(1'(s_rlast >> p)), 64'(m_rlast));
    end
    obs_ard = s_arready;
    obs_rv  = s_rvalid;
    obs_rr  = m_rready;
    rhs = (p < S) && m_rvalid && exp_rr && m_rlast;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < S; i++) cnt[i] = 0;
      last_gnt = 0;
      ar_vld   = 0;
      dec_exp  = 0;
    end else begin
      if (gp >= 0) begin
        cnt[gp]++;
        last_gnt = gp;
        ar_vld   = 1;
        ar_id    = {2'(gp), tb_arid[gp]};
        ar_addr  = tb_araddr[gp];
        ar_len   = tb_arlen[gp];
      end else if (m_arready) begin
        ar_vld = 0;
      end
      if (rhs && cnt[p] > 0) cnt[p]--;
      dec_exp = m_rvalid && (p >= S);
    end
    @(negedge clk);
    chk("m_arvalid", 64'(m_arvalid), 64'(ar_vld));
    if (ar_vld) begin
      chk("m_arid", 64'(m_arid), 64'(ar_id));
      chk("m_araddr", 64'(m_araddr), 64'(ar_addr));
      chk("m_arlen", 64'(m_arlen), 64'(ar_len));
      chk("m_arburst", 64'(m_arburst), 64'(BURST_INCR));
    end
    chk("decode_err", 64'(decode_err), 64'(dec_exp));
  endtask

  task automatic idle();
    s_arvalid = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    s_rready  = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    m_rid = '0; m_rdata = '0; m_rresp = '0;
    for (int i = 0; i < S; i++) begin
      tb_arid[i] = 8'(8'h10 + i); tb_araddr[i] = 32'(32'h1000 * (i + 1)); tb_arlen[i] = 8'(i);
    end
    for (int i = 0; i < S; i++) cnt[i] = 0;
    last_gnt = 0; ar_vld = 0; dec_exp = 0; ar_id = '0; ar_addr = '0; ar_len = '0;

    // Reset state
    repeat (2) cycle();
    chk("rst_arvalid", 64'(m_arvalid), 64'd0);
    rst = 1'b0;

    // Two ports requesting continuously: grants alternate 1,0,1,0
    s_arvalid = 3'b011; m_arready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("alt_grant", 64'(obs_ard), (k % 2 == 0) ? 64'b010 : 64'b001);
      chk("alt_arid8", 64'(m_arid[8]), (k % 2 == 0) ? 64'd1 : 64'd0);
    end
    idle(); rst = 1'b1; cycle(); rst = 1'b0;

    // Port 0 saturates its outstanding limit, then one rlast beat frees a slot
    s_arvalid = 3'b001; m_arready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tb_araddr[0] = 32'(32'h2000 + 64 * k);
      cycle();
      chk("fill_grant", 64'(obs_ard), 64'b001);
    end
    repeat (2) begin
      cycle();
      chk("stall5", 64'(obs_ard[0]), 64'd0);
    end
    m_rvalid = 1'b1; m_rid = 10'h011; m_rlast = 1'b1; s_rready = 3'b001;
    m_rdata = 32'hCAFE0001;
    cycle();
    chk("stall_during_r", 64'(obs_ard[0]), 64'd0);
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = '0;
    cycle();
    chk("resume", 64'(obs_ard[0]), 64'd1);
    idle(); rst = 1'b1; cycle(); rst = 1'b0;

    // Downstream back-pressure: payload held, no further grants
    s_arvalid = 3'b011; m_arready = 1'b0;
    cycle();
    chk("bp_first_grant", 64'(obs_ard), 64'b010);
    held_id = m_arid; held_addr = m_araddr;
    for (int k = 0; k < 5; k++) begin
      tb_araddr[0] = $urandom; tb_araddr[1] = $urandom;
      tb_arid[0] = 8'($urandom); tb_arid[1] = 8'($urandom);
      cycle();
      chk("bp_no_pulse", 64'(obs_ard), 64'd0);
      chk("bp_arid_stable", 64'(m_arid), 64'(held_id));
      chk("bp_addr_stable", 64'(m_araddr), 64'(held_addr));
    end
    s_arvalid = '0; m_arready = 1'b1;
    cycle();
    chk("bp_release", 64'(m_arvalid), 64'd0);

    // R routing to port 1 with back-pressure, then accepted
    idle();
    m_rvalid = 1'b1; m_rid = 10'h1A5; m_rlast = 1'b1; m_rdata = 32'h5A5A1234;
    repeat (2) begin
      cycle();
      chk("route_rv", 64'(obs_rv), 64'b010);
      chk("route_rid", 64'(8'(s_rid >> SID)), 64'hA5);
      chk("route_rready", 64'(obs_rr), 64'd0);
    end
    s_rready = 3'b010;
    cycle();
    chk("route_accept", 64'(obs_rr), 64'd1);

    // Out-of-range port index: beat dropped with one decode_err pulse
    m_rid = 10'h3C7; s_rready = '0;
    cycle();
    chk("dec_rready", 64'(obs_rr), 64'd1);
    chk("dec_no_rvalid", 64'(obs_rv), 64'd0);
    chk("dec_pulse", 64'(decode_err), 64'd1);
    idle();
    cycle();
    chk("dec_pulse_end", 64'(decode_err), 64'd0);

    // Reset while an AR is pending and port 0 has two open bursts
    s_arvalid = 3'b001; m_arready = 1'b0;
    cycle();
    m_arready = 1'b1;
    cycle();
    chk("pre_rst_arvalid", 64'(m_arvalid), 64'd1);
    rst = 1'b1;
    cycle();
    chk("mid_rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("mid_rst_arready", 64'(obs_ard), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("post_rst_grant", 64'(obs_ard), 64'b001);
    end
    cycle();
    chk("post_rst_stall", 64'(obs_ard), 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      s_arvalid = 3'($urandom);
      m_arready = 1'($urandom);
      for (int i = 0; i < S; i++) begin
        tb_arid[i] = 8'($urandom); tb_araddr[i] = $urandom; tb_arlen[i] = 8'($urandom);
      end
      m_rvalid = ($urandom_range(0, 2) != 0);
      m_rid    = {2'($urandom_range(0, 3)), 8'($urandom)};
      m_rlast  = 1'($urandom);
      m_rdata  = $urandom;
      m_rresp  = 2'($urandom);
      s_rready = 3'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
